// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the MMIO address map, the UART transmitter state encoding and a
// helper that locates the lowest enabled byte lane of a store.
package riscv_pkg;

   localparam logic [31:0] MMIO_LED_ADDR       = 32'hFFFF_FFF0;
   localparam logic [31:0] MMIO_UART_DATA_ADDR = 32'hFFFF_FFF4;
   localparam logic [31:0] MMIO_UART_STAT_ADDR = 32'hFFFF_FFF8;
   localparam logic [31:0] MMIO_CYCLE_ADDR     = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   // Index of the lowest set byte enable; 0 when none is set.
   function automatic logic [1:0] lowest_lane(input logic [3:0] be);
      logic [1:0] lane;
      lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (be[i]) lane = 2'(i);
      end
      return lane;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request to send 'data'; honoured only while idle
//   data[7:0]  : byte to transmit, latched on an accepted start
//   busy       : high from the cycle after an accepted start until the
//                end of the stop bit
//   tx         : serial line, idles high
module uart_tx_core
   import riscv_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   uart_state_t       state;
   logic [BAUD_W-1:0] baud;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              bit_done;

   assign bit_done = (baud == BAUD_LAST);

   // Frame sequencer; tx and busy are registered alongside the state so
   // they change on the same edge as the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= UART_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         busy    <= 1'b0;
         tx      <= 1'b1;
      end else begin
         if (state != UART_IDLE) begin
            baud <= bit_done ? '0 : baud + 1'b1;
         end
         case (state)
            UART_IDLE: begin
               if (start) begin
                  state <= UART_START;
                  baud  <= '0;
                  shreg <= data;
                  busy  <= 1'b1;
                  tx    <= 1'b0;
               end
            end
            UART_START: begin
               if (bit_done) begin
                  state   <= UART_DATA;
                  bit_idx <= '0;
                  tx      <= shreg[0];
               end
            end
            UART_DATA: begin
               if (bit_done) begin
                  if (bit_idx == 3'd7) begin
                     state <= UART_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end
            end
            UART_STOP: begin
               if (bit_done) begin
                  state <= UART_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= UART_IDLE;
               busy  <= 1'b0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's data port: word RAM with byte-lane
// stores plus an MMIO window (LEDs, UART TX data/status, cycle counter).
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   dmem_addr    : byte address
//   dmem_wdata   : unshifted store data
//   dmem_we      : write strobe
//   dmem_be      : byte-lane enables (RAM only)
//   dmem_rdata   : combinational read data for dmem_addr
//   leds_out     : LED register
//   uart_tx      : 8N1 serial output
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_WORDS    = 4096,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic        dmem_we,
   input  logic [3:0]  dmem_be,
   output logic [31:0] dmem_rdata,
   output logic [3:0]  leds_out,
   output logic        uart_tx
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   logic [31:0]      mem [MEM_WORDS];
   logic [31:0]      cycle_cnt;
   logic             overrun;
   logic             uart_busy;

   logic             ram_sel_c;
   logic [IDX_W-1:0] widx_c;
   logic [31:0]      lane_data_c;
   logic             led_wr_c;
   logic             tx_wr_c;
   logic             stat_wr_c;
   logic             tx_start_c;
   logic             tx_drop_c;

   // Decode: RAM occupies [0, MEM_WORDS*4); MMIO registers are exact matches.
   assign ram_sel_c   = (dmem_addr >> (IDX_W + 2)) == 32'd0;
   assign widx_c      = dmem_addr[IDX_W+1:2];
   assign lane_data_c = dmem_wdata << {lowest_lane(dmem_be), 3'b000};
   assign led_wr_c    = dmem_we && (dmem_addr == MMIO_LED_ADDR);
   assign tx_wr_c     = dmem_we && (dmem_addr == MMIO_UART_DATA_ADDR);
   assign stat_wr_c   = dmem_we && (dmem_addr == MMIO_UART_STAT_ADDR);
   assign tx_start_c  = tx_wr_c && !uart_busy;
   assign tx_drop_c   = tx_wr_c && uart_busy;

   // RAM byte-lane stores; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (dmem_we && ram_sel_c) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_be[i]) mem[widx_c][8*i +: 8] <= lane_data_c[8*i +: 8];
         end
      end
   end

   // LED register, free-running cycle counter and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds_out  <= 4'd0;
         cycle_cnt <= 32'd0;
         overrun   <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (led_wr_c) leds_out <= dmem_wdata[3:0];
         // A dropped byte wins over a same-edge clear.
         if (tx_drop_c) begin
            overrun <= 1'b1;
         end else if (stat_wr_c && dmem_wdata[1]) begin
            overrun <= 1'b0;
         end
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tx_start_c),
      .data  (dmem_wdata[7:0]),
      .busy  (uart_busy),
      .tx    (uart_tx)
   );

   // Combinational read mux; TX data and unmapped addresses read as zero.
   always_comb begin
      dmem_rdata = 32'd0;
      if (ram_sel_c) begin
         dmem_rdata = mem[widx_c];
      end else begin
         case (dmem_addr)
            MMIO_LED_ADDR:       dmem_rdata = {28'd0, leds_out};
            MMIO_UART_STAT_ADDR: dmem_rdata = {30'd0, overrun, uart_busy};
            MMIO_CYCLE_ADDR:     dmem_rdata = cycle_cnt;
            default:             dmem_rdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of directed vectors,
// hand-written UART/overrun/reset sequences, then randomized traffic
// compared against a byte-array/timestamp reference model.
module tb_dmem_responder;

   localparam int unsigned MEMW = 256;
   localparam int unsigned CPB  = 4;
   localparam int unsigned FRAME = 10 * CPB;

   logic        clk;
   logic        rst_n;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic [3:0]  leds_out;
   logic        uart_tx;

   dmem_responder #(
      .MEM_WORDS    (MEMW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_be    (dmem_be),
      .dmem_rdata (dmem_rdata),
      .leds_out   (leds_out),
      .uart_tx    (uart_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int unsigned t = 0;          // cycles since the last reset release

   // Reference model state
   logic [7:0]  mb [MEMW*4];
   logic [3:0]  m_leds;
   logic        m_ovr;
   logic        m_has;
   int unsigned m_start;
   logic [7:0]  m_byte;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  be;
      logic        chk;
      logic [31:0] exp;
      logic [3:0]  leds;
   } vec_t;

   vec_t tbl[$];
   int   a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic we, input logic [3:0] be);
      dmem_addr  = a;
      dmem_wdata = w;
      dmem_we    = we;
      dmem_be    = be;
   endtask

   // Expected serial level at frame offset k (k=0 is the first cycle after acceptance).
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      int j;
      j = k / CPB;
      if (j == 0) return 1'b0;
      if (j >= 9) return 1'b1;
      return b[j-1];
   endfunction

   function automatic logic m_busy();
      return m_has && (t >= m_start + 1) && (t <= m_start + FRAME);
   endfunction

   function automatic logic m_tx();
      if (!m_busy()) return 1'b1;
      return exp_bit(m_byte, int'(t - m_start - 1));
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      int w;
      if (a < 32'(MEMW*4)) begin
         w = int'(a / 4);
         return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
      end
      if (a == 32'hFFFF_FFF0) return {28'd0, m_leds};
      if (a == 32'hFFFF_FFF8) return {30'd0, m_ovr, m_busy()};
      if (a == 32'hFFFF_FFFC) return t;
      return 32'd0;
   endfunction

   task automatic model_reset();
      m_leds = 4'd0;
      m_ovr  = 1'b0;
      m_has  = 1'b0;
      t      = 0;
   endtask

   // Apply the current write (if any) to the model, using pre-edge state.
   task automatic model_update();
      int w;
      int sh;
      logic [31:0] sd;
      if (!dmem_we) return;
      if (dmem_addr < 32'(MEMW*4)) begin
         w  = int'(dmem_addr / 4);
         sh = -1;
         for (int i = 0; i < 4; i++) if (dmem_be[i] && sh < 0) sh = i;
         if (sh >= 0) begin
            sd = dmem_wdata << (8 * sh);
            for (int i = 0; i < 4; i++) if (dmem_be[i]) mb[w*4+i] = sd[8*i +: 8];
         end
      end else if (dmem_addr == 32'hFFFF_FFF0) begin
         m_leds = dmem_wdata[3:0];
      end else if (dmem_addr == 32'hFFFF_FFF4) begin
         if (m_busy()) m_ovr = 1'b1;
         else begin
            m_has   = 1'b1;
            m_start = t;
            m_byte  = dmem_wdata[7:0];
         end
      end else if (dmem_addr == 32'hFFFF_FFF8) begin
         if (dmem_wdata[1]) m_ovr = 1'b0;
      end
   endtask

   task automatic step(input bit do_chk);
      #1;
      if (do_chk) begin
         check("rnd_rdata", dmem_rdata, exp_read(dmem_addr));
         check("rnd_uart_tx", 32'(uart_tx), 32'(m_tx()));
         check("rnd_leds", 32'(leds_out), 32'(m_leds));
      end
      model_update();
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int op;
      rst_n = 1'b0;
      drive(32'd0, 32'd0, 1'b0, 4'd0);
      model_reset();

      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      #1;
      check("reset_leds", 32'(leds_out), 32'd0);
      check("reset_uart_tx", 32'(uart_tx), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      drive(32'hFFFF_FFFC, 32'd0, 1'b0, 4'd0);
      #1;
      check("reset_counter", dmem_rdata, 32'd0);
      dmem_addr = 32'hFFFF_FFF8;
      #1;
      check("reset_status", dmem_rdata, 32'd0);
      tick();

      // ---------------- directed table ----------------
      tbl.push_back('{32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0, 32'd0,          4'd0});
      tbl.push_back('{32'h0000_0010, 32'h1122_3344, 1'b1, 4'b1111, 1'b0, 32'd0,          4'd0});
      tbl.push_back('{32'h0000_0011, 32'h0000_00AB, 1'b1, 4'b0010, 1'b0, 32'd0,          4'd0});
      tbl.push_back('{32'h0000_0012, 32'h0000_CDEF, 1'b1, 4'b1100, 1'b0, 32'd0,          4'd0});
      tbl.push_back('{32'h0000_0010, 32'd0,         1'b0, 4'b0000, 1'b1, 32'hCDEF_AB44, 4'd0});
      tbl.push_back('{32'hFFFF_FFF0, 32'h0000_0005, 1'b1, 4'b0000, 1'b0, 32'd0,          4'd0});
      tbl.push_back('{32'hFFFF_FFF0, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h0000_0005, 4'd5});
      tbl.push_back('{32'h8000_0000, 32'h1234_5678, 1'b1, 4'b1111, 1'b0, 32'd0,          4'd5});
      tbl.push_back('{32'h8000_0000, 32'd0,         1'b0, 4'b0000, 1'b1, 32'd0,          4'd5});
      tbl.push_back('{32'h0000_0000, 32'd0,         1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 4'd5});
      tbl.push_back('{32'h0000_0004, 32'h0102_0304, 1'b1, 4'b1111, 1'b0, 32'd0,          4'd5});
      tbl.push_back('{32'h0000_0004, 32'hFFFF_FFFF, 1'b1, 4'b0000, 1'b0, 32'd0,          4'd5});
      tbl.push_back('{32'h0000_0004, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h0102_0304, 4'd5});
      tbl.push_back('{32'h0000_0008, 32'd0,         1'b1, 4'b1111, 1'b0, 32'd0,          4'd5});
      tbl.push_back('{32'h0000_0008, 32'h0000_00EE, 1'b1, 4'b0100, 1'b0, 32'd0,          4'd5});
      tbl.push_back('{32'h0000_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h00EE_0000, 4'd5});
      tbl.push_back('{32'hFFFF_FFF4, 32'd0,         1'b0, 4'b0000, 1'b1, 32'd0,          4'd5});
      foreach (tbl[i]) begin
         drive(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].be);
         #1;
         if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), dmem_rdata, tbl[i].exp);
         check($sformatf("tbl%0d_leds", i), 32'(leds_out), 32'(tbl[i].leds));
         tick();
      end

      // ---------------- UART frame 0xA5 ----------------
      drive(32'hFFFF_FFF4, 32'h0000_00A5, 1'b1, 4'b1111);
      tick();
      drive(32'hFFFF_FFF8, 32'd0, 1'b0, 4'd0);
      for (int k = 0; k < int'(FRAME); k++) begin
         #1;
         check("frame_tx", 32'(uart_tx), 32'(a5_seq[k / CPB]));
         check("frame_busy", dmem_rdata, 32'd1);
         tick();
      end
      #1;
      check("frame_end_status", dmem_rdata, 32'd0);
      check("frame_end_tx", 32'(uart_tx), 32'd1);
      tick();

      // ---------------- overrun ----------------
      drive(32'hFFFF_FFF4, 32'h0000_003C, 1'b1, 4'b0001);
      tick();
      for (int k = 0; k < int'(FRAME); k++) begin
         if (k == 4)      drive(32'hFFFF_FFF4, 32'h0000_00FF, 1'b1, 4'b1111);
         else if (k == 6) drive(32'hFFFF_FFF8, 32'h0000_0002, 1'b1, 4'b0000);
         else             drive(32'hFFFF_FFF8, 32'd0, 1'b0, 4'd0);
         #1;
         check("ovr_tx", 32'(uart_tx), 32'(exp_bit(8'h3C, k)));
         if (k != 4) check("ovr_status", dmem_rdata, (k >= 5 && k <= 6) ? 32'd3 : 32'd1);
         tick();
      end
      drive(32'hFFFF_FFF8, 32'd0, 1'b0, 4'd0);
      #1;
      check("ovr_end_status", dmem_rdata, 32'd0);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("ovr_no_second_frame", 32'(uart_tx), 32'd1);
         tick();
      end

      // ---------------- mid-frame reset ----------------
      drive(32'hFFFF_FFF4, 32'h0000_0000, 1'b1, 4'b1111);
      tick();
      drive(32'hFFFF_FFF8, 32'd0, 1'b0, 4'd0);
      for (int k = 0; k < 10; k++) begin
         #1;
         check("mid_tx_pre", 32'(uart_tx), 32'd0);
         tick();
      end
      rst_n = 1'b0;
      #1;
      check("mid_reset_tx", 32'(uart_tx), 32'd1);
      check("mid_reset_leds", 32'(leds_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      check("mid_reset_status", dmem_rdata, 32'd0);
      tick();
      for (int k = 0; k < int'(FRAME); k++) begin
         #1;
         check("mid_abandoned_tx", 32'(uart_tx), 32'd1);
         tick();
      end

      // ---------------- random traffic vs model ----------------
      // The model's clock restarts at the reset release above.
      model_reset();
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int w = 0; w < int'(MEMW); w++) begin
         if (w == 0) tick();
         drive(32'(w * 4), $urandom, 1'b1, 4'b1111);
         step(1'b0);
      end
      for (int i = 0; i < 3000; i++) begin
         op = int'($urandom_range(0, 99));
         drive(32'($urandom_range(0, MEMW*4 - 1)), $urandom, 1'b0, 4'($urandom));
         if (op < 35) begin
            dmem_we = 1'b1;
         end else if (op < 60) begin
            dmem_we = 1'b0;
         end else if (op < 68) begin
            drive(32'hFFFF_FFF0, $urandom, 1'b1, 4'($urandom));
         end else if (op < 78) begin
            drive(32'hFFFF_FFF4, $urandom, 1'b1, 4'($urandom));
         end else if (op < 83) begin
            drive(32'hFFFF_FFF8, $urandom, 1'b1, 4'($urandom));
         end else if (op < 88) begin
            drive(32'hFFFF_FFFC, $urandom, 1'b1, 4'($urandom));
         end else if (op < 94) begin
            if ($urandom_range(0, 1) == 0)
               dmem_addr = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
            else
               dmem_addr = 32'(MEMW*4) + 32'($urandom_range(0, 100)) * 4;
            dmem_we = 1'($urandom);
         end else begin
            dmem_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            dmem_we   = 1'b0;
         end
         step(1'b1);
      end

      // ---------------- counter wrap ----------------
      drive(32'hFFFF_FFFC, 32'd0, 1'b0, 4'd0);
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      check("wrap_pre", dmem_rdata, 32'hFFFF_FFFF);
      release dut.cycle_cnt;
      tick();
      check("wrap_post", dmem_rdata, 32'd0);
      tick();
      check("wrap_next", dmem_rdata, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
